// File: rtl/split_checker.sv
// ============================================================================
// Module   : split_checker
// Purpose  : Streams one frame of NUM_VARS unsigned variables and reports
//            whether every value is in [LO,HI] and the running sum stays
//            within SUM_MAX, plus length errors and the first failing index.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module split_checker #(
    parameter int NUM_VARS = 40,
    parameter int VAR_W    = 8,
    parameter int LO       = 0,
    parameter int HI       = 2**VAR_W - 1,
    parameter int SUM_MAX  = NUM_VARS * (2**VAR_W - 1),
    parameter int MODE     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [VAR_W-1:0]            in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        x,
    output logic                        len_err,
    output logic [$clog2(NUM_VARS)-1:0] fail_idx
);

    localparam int IDX_W = $clog2(NUM_VARS);
    localparam int SUM_W = VAR_W + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VARS - 1);
    localparam logic [31:0]      SUM_MAX_U = SUM_MAX;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_add;
    logic             fail_seen;
    logic             accept;
    logic             release_v;
    logic             below;
    logic             above;
    logic             beat_fail;
    logic             at_last_idx;
    logic             frame_end;
    logic             len_now;

    // Bounds that cannot exclude any value are tied off to avoid constant compares.
    generate
        if (LO > 0) begin : g_lo_chk
            assign below = (in_data < VAR_W'(LO));
        end else begin : g_lo_none
            assign below = 1'b0;
        end
        if (HI < 2**VAR_W - 1) begin : g_hi_chk
            assign above = (in_data > VAR_W'(HI));
        end else begin : g_hi_none
            assign above = 1'b0;
        end
    endgenerate

    assign accept      = in_valid && in_ready;
    assign release_v   = out_valid && out_ready;
    assign sum_add     = sum + SUM_W'(in_data);
    assign at_last_idx = (idx == LAST_IDX);
    assign frame_end   = in_last || at_last_idx;
    assign len_now     = (in_last != at_last_idx);

    always_comb begin
        beat_fail = 1'b0;
        if (MODE >= 1 && (below || above))
            beat_fail = 1'b1;
        if (MODE == 2 && (32'(sum_add) > SUM_MAX_U))
            beat_fail = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (accept && frame_end) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)           state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACC);
        out_valid = (state == ST_DONE);
    end

    // Verdict registers hold through DONE and are cleared by the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            sum       <= '0;
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            x         <= 1'b0;
            len_err   <= 1'b0;
        end else if (release_v) begin
            idx       <= '0;
            sum       <= '0;
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            x         <= 1'b0;
            len_err   <= 1'b0;
        end else if (accept) begin
            idx <= idx + IDX_W'(1);
            sum <= sum_add;
            if (beat_fail && !fail_seen) begin
                fail_seen <= 1'b1;
                fail_idx  <= idx;
            end
            if (frame_end) begin
                x       <= !(fail_seen || beat_fail) && !len_now;
                len_err <= len_now;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_split_checker.sv
// ============================================================================
// Module   : tb_split_checker
// Purpose  : Directed and randomized frames for split_checker, compared
//            against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_split_checker;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int LO   = 2;
    localparam int HI   = 200;
    localparam int SMAX = 300;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         x;
    logic         len_err;
    logic [1:0]   fail_idx;

    int n_checks = 0;
    int n_errors = 0;
    int fd [N];

    split_checker #(
        .NUM_VARS(N), .VAR_W(W), .LO(LO), .HI(HI), .SUM_MAX(SMAX), .MODE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .len_err(len_err), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        fd[0] = a; fd[1] = b; fd[2] = c; fd[3] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_x"},         x,         0);
        check({tag, "_len_err"},   len_err,   0);
        check({tag, "_fail_idx"},  fail_idx,  0);
    endtask

    // Frame of n beats from fd[]; last marks whether the final beat carries in_last.
    task automatic run_frame(input int n, input bit last, input int stall);
        int sum = 0;
        int fidx = 0;
        bit failed = 0;
        bit exp_len;
        bit exp_x;
        for (int i = 0; i < n; i++) begin
            sum += fd[i];
            if ((fd[i] < LO || fd[i] > HI || sum > SMAX) && !failed) begin
                failed = 1;
                fidx = i;
            end
        end
        exp_len = !(n == N && last);
        exp_x   = !failed && !exp_len;

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("in_ready_acc", in_ready, 1);
            check("out_valid_acc", out_valid, 0);
            in_valid = 1'b1;
            in_data  = W'(fd[i]);
            in_last  = last && (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("out_valid", out_valid, 1);
        check("x", x, exp_x);
        check("len_err", len_err, exp_len);
        check("fail_idx", fail_idx, fidx);

        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_x", x, exp_x);
            check("stall_len_err", len_err, exp_len);
            check("stall_fail_idx", fail_idx, fidx);
        end

        // Garbage beat offered during the handshake cycle must be ignored.
        in_valid  = 1'b1;
        in_data   = 8'd250;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        set4(10, 20, 30, 40);   run_frame(4, 1, 0);
        set4(10, 250, 1, 5);    run_frame(4, 1, 0);
        set4(100, 100, 100, 50); run_frame(4, 1, 0);
        set4(5, 6, 0, 0);       run_frame(2, 1, 0);
        set4(7, 8, 9, 10);      run_frame(4, 0, 0);
        set4(10, 20, 30, 40);   run_frame(4, 1, 5);

        // Reset mid-frame: partial sum 290 must not leak into the next frame.
        set4(150, 140, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'(fd[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        set4(10, 20, 30, 40);   run_frame(4, 1, 0);

        // Reset while holding a verdict discards it.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'd20;
            in_last  = (i == N - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("done_before_reset", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("donereset");
        rst_n = 1'b1;

        for (int f = 0; f < 300; f++) begin
            int n;
            bit last;
            n = $urandom_range(1, N);
            last = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++)
                fd[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(2, 90);
            run_frame(n, last, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
